// File: rtl/dmem_port_arbiter.sv
// Shares the data-memory port between the MEM stage (priority) and a debug dump engine
// that reads idle cycles, stealing one cycle after STARVE_LIMIT busy cycles.
module dmem_port_arbiter #(
    parameter int unsigned CNT_W        = 10,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             PipeMemRead,
    input  logic             PipeMemWrite,
    input  logic [31:0]      PipeAddress,
    input  logic [31:0]      PipeWriteData,
    input  logic [1:0]       PipeByteSig,
    output logic [31:0]      PipeReadData,
    output logic             PipeStall,
    input  logic             DbgStart,
    input  logic [31:0]      DbgBaseAddr,
    input  logic [CNT_W-1:0] DbgWordCount,
    output logic [31:0]      DbgData,
    output logic             DbgValid,
    input  logic             DbgReady,
    output logic             DbgBusy,
    output logic             DbgDone,
    output logic             MemRead,
    output logic             MemWrite,
    output logic [31:0]      MemAddress,
    output logic [31:0]      MemWriteData,
    output logic [1:0]       MemByteSig,
    input  logic [31:0]      MemReadData
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              valid_q, valid_d;

    logic              pipe_busy;
    logic              grant;
    logic              steal;

    always_comb begin
        pipe_busy = PipeMemRead | PipeMemWrite;
        grant     = !pipe_busy || (starve_q == LIM);
        steal     = (state_q == S_FETCH) && grant;
    end

    // A stolen slot is always a plain word read, so the pipeline never shares a write cycle.
    always_comb begin
        if (steal) begin
            MemRead      = 1'b1;
            MemWrite     = 1'b0;
            MemAddress   = addr_q;
            MemWriteData = '0;
            MemByteSig   = 2'b00;
        end else begin
            MemRead      = PipeMemRead;
            MemWrite     = PipeMemWrite;
            MemAddress   = PipeAddress;
            MemWriteData = PipeWriteData;
            MemByteSig   = PipeByteSig;
        end
        PipeReadData = MemReadData;
        PipeStall    = steal & pipe_busy;
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        rem_d    = rem_q;
        starve_d = starve_q;
        valid_d  = valid_q;
        unique case (state_q)
            S_IDLE: begin
                if (DbgStart) begin
                    addr_d   = DbgBaseAddr;
                    rem_d    = DbgWordCount;
                    starve_d = '0;
                    state_d  = (DbgWordCount == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (grant) begin
                    data_d   = MemReadData;
                    valid_d  = 1'b1;
                    addr_d   = addr_q + 32'd4;
                    rem_d    = rem_q - CNT_W'(1);
                    starve_d = '0;
                    state_d  = S_HOLD;
                end else if (starve_q != LIM) begin
                    starve_d = starve_q + SW'(1);
                end
            end
            S_HOLD: begin
                if (DbgReady) begin
                    valid_d = 1'b0;
                    state_d = (rem_q != '0) ? S_FETCH : S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            rem_q    <= '0;
            starve_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            rem_q    <= rem_d;
            starve_q <= starve_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        DbgData  = data_q;
        DbgValid = valid_q;
        DbgBusy  = (state_q != S_IDLE);
        DbgDone  = (state_q == S_DONE);
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Random and directed stimulus against a cycle-level port model plus a dump-word scoreboard.
module tb_dmem_port_arbiter;

    localparam int unsigned CNT_W = 10;
    localparam int unsigned LIMIT = 8;

    logic             Clock = 1'b0;
    logic             Reset;
    logic             PipeMemRead, PipeMemWrite;
    logic [31:0]      PipeAddress, PipeWriteData;
    logic [1:0]       PipeByteSig;
    logic [31:0]      PipeReadData;
    logic             PipeStall;
    logic             DbgStart;
    logic [31:0]      DbgBaseAddr;
    logic [CNT_W-1:0] DbgWordCount;
    logic [31:0]      DbgData;
    logic             DbgValid, DbgReady, DbgBusy, DbgDone;
    logic             MemRead, MemWrite;
    logic [31:0]      MemAddress, MemWriteData;
    logic [1:0]       MemByteSig;
    logic [31:0]      MemReadData;

    dmem_port_arbiter #(.CNT_W(CNT_W), .STARVE_LIMIT(LIMIT)) dut (
        .Clock(Clock), .Reset(Reset),
        .PipeMemRead(PipeMemRead), .PipeMemWrite(PipeMemWrite),
        .PipeAddress(PipeAddress), .PipeWriteData(PipeWriteData),
        .PipeByteSig(PipeByteSig), .PipeReadData(PipeReadData),
        .PipeStall(PipeStall), .DbgStart(DbgStart),
        .DbgBaseAddr(DbgBaseAddr), .DbgWordCount(DbgWordCount),
        .DbgData(DbgData), .DbgValid(DbgValid), .DbgReady(DbgReady),
        .DbgBusy(DbgBusy), .DbgDone(DbgDone),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemAddress(MemAddress),
        .MemWriteData(MemWriteData), .MemByteSig(MemByteSig),
        .MemReadData(MemReadData)
    );

    always #5 Clock = ~Clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign MemReadData = mem_word(MemAddress);

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: dump progress expressed as flags and counters.
    bit          m_busy, m_pending, m_hold, m_done;
    logic [31:0] m_addr, m_data;
    int unsigned m_rem, m_wait;
    logic [31:0] sb_q[$];
    int unsigned stall_cnt;

    task automatic model_reset();
        m_busy = 0; m_pending = 0; m_hold = 0; m_done = 0;
        m_addr = '0; m_data = '0; m_rem = 0; m_wait = 0;
        sb_q.delete();
    endtask

    task automatic pipe_idle();
        PipeMemRead = 0; PipeMemWrite = 0; PipeAddress = '0;
        PipeWriteData = '0; PipeByteSig = 2'b00;
    endtask

    task automatic step();
        bit pb, st;
        @(negedge Clock);
        pb = PipeMemRead | PipeMemWrite;
        st = m_pending && (!pb || m_wait == LIMIT);
        chk("MemRead",      MemRead,      st ? 1'b1 : PipeMemRead);
        chk("MemWrite",     MemWrite,     st ? 1'b0 : PipeMemWrite);
        chk("MemAddress",   MemAddress,   st ? m_addr : PipeAddress);
        chk("MemWriteData", MemWriteData, st ? 32'd0 : PipeWriteData);
        chk("MemByteSig",   MemByteSig,   st ? 2'b00 : PipeByteSig);
        chk("PipeStall",    PipeStall,    st & pb);
        chk("PipeReadData", PipeReadData, mem_word(MemAddress));
        chk("DbgValid",     DbgValid,     m_hold);
        chk("DbgBusy",      DbgBusy,      m_busy);
        chk("DbgDone",      DbgDone,      m_done);
        if (m_hold) chk("DbgData", DbgData, m_data);
        if (PipeStall) stall_cnt++;
        if (DbgValid && DbgReady) begin
            if (sb_q.size() == 0) chk("sb_extra", 1, 0);
            else chk("sb_word", DbgData, sb_q.pop_front());
        end
        if (DbgDone) chk("sb_left", sb_q.size(), 0);

        if (m_done) begin
            m_done = 0; m_busy = 0;
        end else if (!m_busy) begin
            if (DbgStart) begin
                m_busy = 1; m_addr = DbgBaseAddr; m_rem = DbgWordCount; m_wait = 0;
                for (int unsigned i = 0; i < DbgWordCount; i++)
                    sb_q.push_back(mem_word(DbgBaseAddr + 32'(4 * i)));
                if (DbgWordCount == 0) m_done = 1; else m_pending = 1;
            end
        end else if (m_pending) begin
            if (st) begin
                m_data = mem_word(m_addr); m_addr = m_addr + 32'd4; m_rem--;
                m_pending = 0; m_hold = 1; m_wait = 0;
            end else if (m_wait < LIMIT) begin
                m_wait++;
            end
        end else if (m_hold && DbgReady) begin
            m_hold = 0;
            if (m_rem != 0) m_pending = 1; else m_done = 1;
        end
        @(posedge Clock);
        #1;
    endtask

    task automatic start_dump(input logic [31:0] base, input int unsigned cnt);
        DbgStart = 1; DbgBaseAddr = base; DbgWordCount = CNT_W'(cnt);
        step();
        DbgStart = 0;
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step();
    endtask

    initial begin
        Reset = 0; pipe_idle(); DbgStart = 0; DbgBaseAddr = '0; DbgWordCount = '0; DbgReady = 1;
        model_reset();
        #12;
        chk("rst_DbgValid", DbgValid, 0);
        chk("rst_DbgData",  DbgData,  0);
        chk("rst_DbgDone",  DbgDone,  0);
        chk("rst_DbgBusy",  DbgBusy,  0);
        chk("rst_PipeStall", PipeStall, 0);
        @(posedge Clock); #1;
        Reset = 1;

        // idle pipeline, three words
        start_dump(32'h40, 3);
        run(10);

        // pipeline write while a read is pending
        start_dump(32'h100, 1);
        PipeMemWrite = 1; PipeAddress = 32'h10; PipeWriteData = 32'hDEAD_BEEF; PipeByteSig = 2'b11;
        step();
        pipe_idle();
        run(5);

        // continuous pipeline reads: exactly one stolen cycle
        PipeMemRead = 1; PipeAddress = 32'h200;
        stall_cnt = 0;
        start_dump(32'h80, 1);
        run(14);
        chk("stall_cnt", stall_cnt, 1);
        pipe_idle();
        run(3);

        // sink back-pressure
        start_dump(32'h300, 2);
        DbgReady = 0;
        run(7);
        DbgReady = 1;
        run(6);

        // zero-length dump, then a start pulse mid-dump
        start_dump(32'h500, 0);
        run(3);
        start_dump(32'h600, 3);
        run(2);
        start_dump(32'h700, 2);
        run(8);

        // reset during HOLD of a four-word dump
        DbgReady = 0;
        start_dump(32'h900, 4);
        run(3);
        #2 Reset = 0;
        #1;
        chk("arst_DbgValid", DbgValid, 0);
        chk("arst_DbgBusy",  DbgBusy,  0);
        chk("arst_DbgDone",  DbgDone,  0);
        chk("arst_MemRead",  MemRead,  0);
        chk("arst_DbgData",  DbgData,  0);
        model_reset();
        @(posedge Clock); #1;
        Reset = 1; DbgReady = 1;
        start_dump(32'hA00, 2);
        run(6);

        // address wrap
        start_dump(32'hFFFF_FFF8, 3);
        run(8);

        // randomized traffic with varying pipeline load
        for (int seg = 0; seg < 60; seg++) begin
            int unsigned load;
            case ($urandom_range(0, 2))
                0: load = 10;
                1: load = 50;
                default: load = 97;
            endcase
            for (int c = 0; c < 50; c++) begin
                bit busy;
                busy = ($urandom_range(0, 99) < load);
                PipeMemRead  = busy && $urandom_range(0, 1) == 0;
                PipeMemWrite = busy && !PipeMemRead;
                PipeAddress  = $urandom & 32'hFFFF_FFFC;
                PipeWriteData = $urandom;
                PipeByteSig  = 2'($urandom_range(0, 3));
                DbgReady     = ($urandom_range(0, 9) < 7);
                DbgStart     = ($urandom_range(0, 9) == 0);
                DbgBaseAddr  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC);
                DbgWordCount = CNT_W'($urandom_range(0, 4));
                step();
            end
        end
        DbgStart = 0; pipe_idle(); DbgReady = 1;
        run(30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Arbitrates the single data-memory port between two requesters: the pipeline MEM stage and a debug dump engine that streams memory contents to the debug/UART unit.
- Sits between the MEM stage and the data memory.
- The pipeline has priority. The dump engine uses idle memory cycles.
- If the pipeline has kept the port busy for STARVE_LIMIT cycles, the dump engine takes one cycle by stalling the pipeline.

Parameters:
- CNT_W, 10, width of dump word counter (max 2^CNT_W-1 words per dump)
- STARVE_LIMIT, 8, consecutive pipeline-busy cycles while a dump read is pending before one cycle is taken by stalling the pipeline (must be >=1)

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- PipeMemRead  in  1  MEM-stage read request
- PipeMemWrite  in  1  MEM-stage write request
- PipeAddress  in  32  MEM-stage byte address (ALU result)
- PipeWriteData  in  32  MEM-stage store data (RT register)
- PipeByteSig  in  2  MEM-stage access size
- PipeReadData  out  32  MemReadData passed through to the pipeline
- PipeStall  out  1  pipeline must hold the MEM stage this cycle
- DbgStart  in  1  one-cycle pulse that starts a dump
- DbgBaseAddr  in  32  dump start address, word aligned
- DbgWordCount  in  CNT_W  number of words to dump
- DbgData  out  32  dumped word
- DbgValid  out  1  DbgData is valid
- DbgReady  in  1  debug sink accepts DbgData
- DbgBusy  out  1  a dump is in progress (state not IDLE)
- DbgDone  out  1  one-cycle pulse at dump completion
- MemRead, MemWrite  out  1  to data memory
- MemAddress, MemWriteData  out  32  to data memory
- MemByteSig  out  2  to data memory
- MemReadData  in  32  from data memory; combinational read, valid in the same cycle as the address

Behaviour:
- Reset (Reset=0, async) puts the block in IDLE and clears registers and outputs:
  - DbgData=0, DbgValid=0, DbgDone=0, PipeStall=0
  - address register=0, remaining count=0, starve counter=0
- Memory mux (combinational):
  - steal=1 only in FETCH when the slot is granted to the dump engine.
  - steal=1: MemRead=1, MemWrite=0, MemAddress=addr_reg, MemByteSig=2'b00 (word), MemWriteData=0.
  - steal=0: Pipe* signals pass straight to Mem*.
- PipeReadData=MemReadData at all times.
- PipeStall = steal & (PipeMemRead|PipeMemWrite).
- pipe_busy = PipeMemRead|PipeMemWrite.
- States:
  - IDLE:
    - DbgStart=1 latches addr_reg=DbgBaseAddr and rem=DbgWordCount.
    - If DbgWordCount=0, go to DONE; otherwise go to FETCH.
  - FETCH:
    - grant = !pipe_busy | (starve==STARVE_LIMIT); steal=grant.
    - On grant: DbgData<=MemReadData, DbgValid<=1, addr_reg<=addr_reg+4 (wraps mod 2^32), rem<=rem-1, starve<=0, go to HOLD.
    - Otherwise starve<=starve+1, saturating at STARVE_LIMIT.
  - HOLD:
    - DbgValid=1 and DbgData stays stable until DbgReady=1.
    - On DbgReady=1: DbgValid<=0, then go to FETCH if rem!=0, otherwise go to DONE.
  - DONE: DbgDone=1 for exactly one cycle, then go to IDLE.
- DbgStart outside IDLE is ignored.
- Throughput is at most one word per 2 cycles; there is no prefetch.
- Pipeline writes always win unless starve==STARVE_LIMIT. A stolen cycle is a read only, so there are never two writers.
- A reset during a dump aborts it immediately: no DbgDone, DbgValid=0, and no memory access is generated.

Test Plan:
- Idle pipeline, DbgBaseAddr=0x40, DbgWordCount=3, DbgReady tied 1 -> MemAddress reads 0x40, 0x44, 0x48 on alternate cycles; DbgData equals memory contents; DbgDone pulses once; DbgBusy low afterwards.
- Pipeline write 0xDEADBEEF to 0x10 while dump is pending -> write reaches memory unaltered, PipeStall=0, dump read deferred to the next idle cycle.
- PipeMemRead held high continuously, STARVE_LIMIT=8, dump of 1 word -> exactly one stall cycle after 8 busy cycles, with PipeStall=1 and MemAddress=dump address; pipeline resumes the next cycle.
- DbgReady held 0 for 5 cycles in HOLD -> DbgValid stays 1, DbgData stable, no memory read issued; accept then proceeds.
- DbgWordCount=0 -> DONE on the cycle after start with no memory read. DbgStart pulsed mid-dump -> ignored.
- Reset asserted during HOLD of a 4-word dump -> all outputs clear asynchronously, no DbgDone; a new dump after release starts from its own base address.
